div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) in the EX stage; the stall initiator for the pipeline controller.
//  Raises hold_flag_o into ctrl's ex_hold_flag_i, which freezes PC/IF/ID/ID_EX while the divide runs.
//  Releases hold in the cycle the result is valid so EX writes back and the pipeline advances.
//  Radix-2 restoring algorithm on operand magnitudes; sign fix-up in the final cycle.
// PARAMETERS
//  DATA_W  32  operand/result width; counter width is $clog2(DATA_W)
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  rst          in   1       reset, synchronous, active-high
//  start_i      in   1       EX holds a divide op; level, held high while instr sits in EX
//  op_i         in   2       00 DIV, 01 DIVU, 10 REM, 11 REMU
//  dividend_i   in   DATA_W  rs1 value, sampled on accept
//  divisor_i    in   DATA_W  rs2 value, sampled on accept
//  waddr_i      in   5       rd index, sampled on accept
//  abort_i      in   1       pipeline flush (prd_fail); kills the op in flight
//  hold_flag_o  out  1       to ctrl ex_hold_flag_i
//  busy_o       out  1       state != IDLE
//  ready_o      out  1       one-cycle pulse: result_o/waddr_o valid
//  result_o     out  DATA_W  quotient or remainder
//  waddr_o      out  5       rd index of the completed op
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  - Reset: state=IDLE, cnt=0, ready_o=0, result_o=0, waddr_o=0; hold_flag_o=0, busy_o=0.
//  - States: IDLE -> CALC -> FINISH -> IDLE; IDLE -> FINISH for divide-by-zero.
//  - IDLE: accept when start_i && !abort_i. Latch op, waddr, |dividend|, |divisor| (signed ops only).
//    Latch neg_q = sign(a)^sign(b), neg_r = sign(a).
//    hold_flag_o = start_i && !abort_i (combinational), so the pipeline freezes in the accept cycle.
//  - Accept with divisor==0: go to FINISH. DIV/DIVU give all-ones; REM/REMU give the dividend unmodified.
//  - CALC: each cycle remainder shifts one bit and subtracts when >= divisor; cnt counts 0..DATA_W-1.
//    Move to FINISH when cnt==DATA_W-1. hold_flag_o=1 throughout.
//  - FINISH: ready_o=1, hold_flag_o=0. result_o is the quotient for op[1]=0 and the remainder for op[1]=1.
//    Negate when the matching neg flag is set and op is signed. Next state is IDLE unconditionally.
//    start_i is ignored in FINISH, because the same instruction is still in EX that cycle.
//  - Latency: accept in cycle 0, CALC in cycles 1..DATA_W, ready_o in cycle DATA_W+1 (33 for 32).
//    Divide-by-zero: ready_o in cycle 1.
//  - Overflow: DIV 0x80000000 / -1 yields 0x80000000 and REM yields 0 through the normal path.
//    Magnitude 2^31 fits the unsigned datapath; no special case.
//  - abort_i has priority in every state: next state IDLE, cnt=0, no ready_o pulse.
//    hold_flag_o=0 in any cycle abort_i is high.
//  - result_o and waddr_o hold their last value outside the ready_o pulse.
//  - A new accept is allowed in the first IDLE cycle after FINISH (back-to-back divides).
//  - rst asserted mid-operation behaves like reset: no ready_o, hold_flag_o low next cycle.
// TESTING
//  - DIVU 100/7, start_i held until ready: hold_flag_o high cycles 0..32; ready_o at cycle 33 with result 14, waddr echoed.
//  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REMU 0xFFFFFFF9/2 -> 1.
//  - DIV x/0 -> 0xFFFFFFFF at cycle 1; REM 0x1234/0 -> 0x1234; hold_flag_o high in cycle 0 only.
//  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; no error.
//  - abort_i at cycle 10: no ready_o, hold_flag_o low from cycle 10; a new start at cycle 11 completes at cycle 44.
//  - start_i kept high through FINISH: exactly one ready_o; back-to-back second div accepted the next cycle.
//  - rst at cycle 5: busy_o=0 and hold_flag_o=0 next cycle; outputs return to zero.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring on magnitudes.
// Stalls the pipeline through hold_flag_o until the result is valid.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic [4:0]        waddr_i,
  input  logic              abort_i,
  output logic              hold_flag_o,
  output logic              busy_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] result_o,
  output logic [4:0]        waddr_o
);
  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [4:0]        waddr_out_q, waddr_out_d;

  logic              hold, ready;
  logic              a_neg, b_neg, ge;
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W-1:0] quo_fix, rem_fix, fin_val;

  always_comb begin
    a_neg   = ~op_i[0] & dividend_i[DATA_W-1];
    b_neg   = ~op_i[0] & divisor_i[DATA_W-1];
    // one extra bit: 2*rem+1 can exceed DATA_W bits for large unsigned divisors
    rem_sh  = {rem_q, quo_q[DATA_W-1]};
    ge      = rem_sh >= {1'b0, dvs_q};
    quo_fix = (neg_quo_q && !op_q[0]) ? -quo_q : quo_q;
    rem_fix = (neg_rem_q && !op_q[0]) ? -rem_q : rem_q;
    fin_val = op_q[1] ? rem_fix : quo_fix;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    waddr_d     = waddr_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    result_d    = result_q;
    waddr_out_d = waddr_out_q;
    hold        = 1'b0;
    ready       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          hold      = 1'b1;
          op_d      = op_i;
          waddr_d   = waddr_i;
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = a_neg ? -dividend_i : dividend_i;
          dvs_d     = b_neg ? -divisor_i : divisor_i;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          state_d   = CALC;
          if (divisor_i == '0) begin
            // preload final values; clearing the sign flags leaves them untouched
            quo_d     = '1;
            rem_d     = dividend_i;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = FINISH;
          end
        end
      end
      CALC: begin
        hold  = 1'b1;
        rem_d = ge ? DATA_W'(rem_sh - {1'b0, dvs_q}) : rem_sh[DATA_W-1:0];
        quo_d = {quo_q[DATA_W-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W-1)) begin
          cnt_d   = '0;
          state_d = FINISH;
        end
      end
      FINISH: begin
        ready       = 1'b1;
        result_d    = fin_val;
        waddr_out_d = waddr_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_i) begin
      state_d     = IDLE;
      cnt_d       = '0;
      hold        = 1'b0;
      ready       = 1'b0;
      op_d        = op_q;
      waddr_d     = waddr_q;
      result_d    = result_q;
      waddr_out_d = waddr_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      waddr_q     <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      result_q    <= '0;
      waddr_out_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      waddr_q     <= waddr_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      result_q    <= result_d;
      waddr_out_q <= waddr_out_d;
    end
  end

  assign hold_flag_o = hold;
  assign busy_o      = state_q != IDLE;
  assign ready_o     = ready;
  assign result_o    = ready ? fin_val : result_q;
  assign waddr_o     = ready ? waddr_q : waddr_out_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: scoreboard of expected results checked on ready_o.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst, start_i, abort_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i, divisor_i, result_o;
  logic [4:0]  waddr_i, waddr_o;
  logic        hold_flag_o, busy_o, ready_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  wa;
  } exp_t;
  exp_t sb[$];

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  div_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .waddr_i(waddr_i),
    .abort_i(abort_i), .hold_flag_o(hold_flag_o), .busy_o(busy_o),
    .ready_o(ready_o), .result_o(result_o), .waddr_o(waddr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard consumer
  always @(negedge clk) begin
    if (!rst && ready_o) begin
      if (sb.size() == 0) begin
        check("spurious_ready", {31'd0, ready_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result_o, e.res);
        check("waddr", {27'd0, waddr_o}, {27'd0, e.wa});
      end
    end
  end

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa);
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; waddr_i = wa;
  endtask

  // call just after a rising edge; returns just after the edge leaving FINISH,
  // with start_i still high (caller decides back-to-back or release)
  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wa,
                       input logic [31:0] exp, input int lat);
    int cyc;
    exp_t e;
    e.res = exp; e.wa = wa;
    sb.push_back(e);
    drive(op, a, b, wa);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (ready_o) break;
      if (cyc == 0 || cyc == lat - 1)
        check({tag, "_hold"}, {31'd0, hold_flag_o}, 32'd1);
      if (cyc > 40) begin
        check({tag, "_timeout"}, cyc, lat);
        break;
      end
      cyc++;
    end
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_hold_at_ready"}, {31'd0, hold_flag_o}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; op_i = 2'b00;
    dividend_i = '0; divisor_i = '0; waddr_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_hold", {31'd0, hold_flag_o}, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    check("rst_waddr", {27'd0, waddr_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    issue("divu_100_7", DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 33);
    start_i = 1'b0;
    check("idle_after", {31'd0, busy_o}, 32'd0);
    check("result_held", result_o, 32'd14);
    @(posedge clk); #1;
    issue("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 33);
    start_i = 1'b0;
    @(posedge clk); #1;
    issue("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 33);
    start_i = 1'b0;
    @(posedge clk); #1;
    issue("remu_big_2", REMU, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'd1, 33);
    start_i = 1'b0;
    @(posedge clk); #1;
    issue("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'd1, 33);
    start_i = 1'b0;
    @(posedge clk); #1;
    issue("divu_max_max", DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd8, 32'd1, 33);
    start_i = 1'b0;
    @(posedge clk); #1;
    issue("div_by0", DIV, 32'd55, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);
    start_i = 1'b0;
    @(posedge clk); #1;
    issue("rem_by0", REM, 32'h1234, 32'd0, 5'd10, 32'h1234, 1);
    start_i = 1'b0;
    @(posedge clk); #1;
    issue("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 33);
    // back-to-back: start_i stays high through FINISH, next op accepted immediately
    issue("rem_ovf_b2b", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 33);
    start_i = 1'b0;
    @(posedge clk); #1;

    // abort at cycle 10, new op at cycle 11 completes at cycle 44
    drive(DIVU, 32'd1000, 32'd3, 5'd13);
    repeat (10) @(posedge clk);
    #1;
    abort_i = 1'b1;
    #1;
    check("abort_hold", {31'd0, hold_flag_o}, 32'd0);
    @(negedge clk);
    check("abort_no_ready", {31'd0, ready_o}, 32'd0);
    @(posedge clk); #1;
    abort_i = 1'b0;
    issue("after_abort", DIVU, 32'd1000, 32'd3, 5'd14, 32'd333, 33);
    start_i = 1'b0;
    @(posedge clk); #1;

    // reset mid-operation
    drive(DIV, 32'd77, 32'd5, 5'd15);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_hold", {31'd0, hold_flag_o}, 32'd0);
    check("midrst_ready", {31'd0, ready_o}, 32'd0);
    check("midrst_result", result_o, 32'd0);
    check("midrst_waddr", {27'd0, waddr_o}, 32'd0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
